dmem_bank_ctrl: RTL and testbench
=================================

Name: dmem_bank_ctrl

Overview:
Parametrised data-memory block for the load/store unit. It extends the plain word RAM with byte-addressed requests, byte-enable stores and sign/zero-extending sub-word loads. It also adds misalignment detection, a configurable read pipeline and an in-order response queue with valid/ready backpressure. It sits between the LSU and the on-chip data RAM.

Parameters:
DATA_W, 32, word width in bits; 32 or 64 only.
ADDR_W, 16, word-address bits; depth = 2**ADDR_W words.
LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..3.
DEPTH, LATENCY+1, response-queue entries; also the outstanding-request limit.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted this cycle when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W+log2(DATA_W/8)  byte address; upper ADDR_W bits select the word, low bits give the byte offset.
req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0], ...).
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
rsp_err  out  1  misaligned or illegal-size request.

Behaviour:
- Reset (RST_N low, asynchronous): req_ready=0 while asserted, then 1 on the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0. Pipeline valid bits, queue pointers and the outstanding counter clear. In-flight responses are discarded.
- Memory contents are not affected by RST_N. The array is zero-initialised at time 0. Stores committed before reset remain.
- Request acceptance: one request per cycle. An outstanding counter O counts requests accepted but not yet popped (rsp_valid && rsp_ready). req_ready = (O < DEPTH), driven from registers only, with no combinational path from rsp_ready.
- Error check at acceptance:
  - Half with addr[0]!=0 is an error.
  - Word with addr[1:0]!=0 is an error.
  - Double with addr[2:0]!=0 is an error.
  - size=11 when DATA_W=32 is an error.
  - An erroring store writes nothing. Every error produces a response with rsp_err=1 and rsp_rdata=0.
- Stores: commit to the array on the acceptance edge. Data is replicated into the addressed lanes and written with a byte-enable mask derived from size and offset; other lanes are unchanged. No read-modify-write.
- Each store still yields one response: rsp_err as computed, rsp_rdata=0.
- Loads: the array is read on the acceptance edge. Lanes are selected by offset, shifted to bit 0, then zero- or sign-extended per req_unsigned. Word loads with DATA_W=32 ignore req_unsigned.
- Ordering: a load accepted the cycle after a store to the same word returns the new data. Because stores commit at acceptance, no forwarding path is needed.
- Latency: a request accepted at edge t delivers its response to the queue so rsp_valid can be 1 in cycle t+LATENCY. If the queue is empty and rsp_ready=1, the response is popped that same cycle.
- Responses are strictly in acceptance order.
- While rsp_valid=1 && rsp_ready=0, rsp_rdata and rsp_err hold stable.
- Throughput: with rsp_ready held 1, the block sustains one request per cycle for any LATENCY.
- Simultaneous accept and pop in one cycle: O is unchanged.
- Queue full: O==DEPTH forces req_ready=0. Pipeline stages never stall, because the credit limit guarantees queue space.
- Pointer wrap-around: queue read and write pointers wrap modulo DEPTH.

Test Plan:
- SB 0x11/0x22/0x33/0x44 to addresses 0x100..0x103, then LW 0x100 -> rsp_rdata=0x44332211, rsp_err=0; each store response has rsp_rdata=0.
- SW 0x0000_8080 to 0x40, then:
  - LB 0x40 -> 0xFFFFFF80.
  - LBU 0x40 -> 0x00000080.
  - LH 0x40 -> 0xFFFF8080.
  - LHU 0x42 -> 0x00000000.
- LW 0x102 -> rsp_err=1, rsp_rdata=0. SH 0x101 with data 0xBEEF -> rsp_err=1, and a following LW 0x100 is unchanged.
- rsp_ready=0 with continuous loads -> exactly DEPTH accepted, then req_ready=0. Raise rsp_ready -> responses drain in order with stable data, and req_ready reasserts the cycle after the first pop.
- LATENCY=3, rsp_ready=1, 8 back-to-back loads -> 8 consecutive rsp_valid cycles starting 3 cycles after the first accept.
- Pulse RST_N low with 2 loads in flight and 1 queued -> rsp_valid drops immediately and no stale response appears. Earlier stores read back intact after reset.

Source files
------------

// File: rtl/dmem_bank_ctrl.sv
// rtl/dmem_bank_ctrl.sv - byte-addressed data RAM with sub-word loads/stores and an in-order response queue
module dmem_bank_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1,
    parameter int DEPTH   = LATENCY + 1
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [1:0]                         req_size,
    input  logic                               req_unsigned,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0] req_addr,
    input  logic [DATA_W-1:0]                  req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic                               rsp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW    = DATA_W + 1;

    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    logic [ADDR_W-1:0] widx;
    logic [OFF_W-1:0]  off;
    logic              acc;
    logic              req_err;
    logic              sign;
    logic [NB-1:0]     wr_be;
    logic [DATA_W-1:0] wr_rep;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] ent_data;
    logic [EW-1:0]     acc_ent;
    logic              rdy_q, rdy_d;

    assign widx      = req_addr[OFF_W +: ADDR_W];
    assign off       = req_addr[OFF_W-1:0];
    assign acc       = req_valid && rdy_q;
    assign req_ready = rdy_q;

    always_comb begin
        int nbytes;
        int top;
        nbytes   = 1 << req_size;
        top      = (8 * nbytes > DATA_W) ? DATA_W - 1 : 8 * nbytes - 1;
        req_err  = ((int'(off) & (nbytes - 1)) != 0) || (nbytes > NB);
        wr_be    = '0;
        wr_rep   = '0;
        ld_data  = '0;
        for (int b = 0; b < NB; b++) begin
            wr_be[b]         = (b >= int'(off)) && (b < int'(off) + nbytes);
            wr_rep[b*8 +: 8] = req_wdata[(b % nbytes)*8 +: 8];
        end
        rd_shift = mem[widx] >> (8 * int'(off));
        sign     = !req_unsigned && rd_shift[top];
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i <= top) ? rd_shift[i] : sign;
        end
        ent_data = (req_we || req_err) ? '0 : ld_data;
        acc_ent  = {req_err, ent_data};
    end

    // Stores land on the acceptance edge, so a following load never needs forwarding.
    always_ff @(posedge CLK) begin
        if (acc && req_we && !req_err) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[widx][b*8 +: 8] <= wr_rep[b*8 +: 8];
            end
        end
    end

    logic          push;
    logic [EW-1:0] push_ent;

    if (LATENCY == 1) begin : g_direct
        assign push     = acc;
        assign push_ent = acc_ent;
    end else begin : g_pipe
        logic          stg_vld_q [LATENCY-1];
        logic          stg_vld_d [LATENCY-1];
        logic [EW-1:0] stg_ent_q [LATENCY-1];
        logic [EW-1:0] stg_ent_d [LATENCY-1];

        always_comb begin
            stg_vld_d[0] = acc;
            stg_ent_d[0] = acc_ent;
            for (int s = 1; s < LATENCY - 1; s++) begin
                stg_vld_d[s] = stg_vld_q[s-1];
                stg_ent_d[s] = stg_ent_q[s-1];
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int s = 0; s < LATENCY - 1; s++) begin
                    stg_vld_q[s] <= 1'b0;
                    stg_ent_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s < LATENCY - 1; s++) begin
                    stg_vld_q[s] <= stg_vld_d[s];
                    stg_ent_q[s] <= stg_ent_d[s];
                end
            end
        end

        assign push     = stg_vld_q[LATENCY-2];
        assign push_ent = stg_ent_q[LATENCY-2];
    end

    logic [EW-1:0] q_mem_q [DEPTH];
    logic [EW-1:0] q_mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d, out_cnt_q, out_cnt_d;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid              = (q_cnt_q != '0);
    assign pop                    = rsp_valid && rsp_ready;
    assign {rsp_err, rsp_rdata}   = rsp_valid ? q_mem_q[rd_ptr_q] : '0;

    // The outstanding credit covers pipeline plus queue, so a push always finds a free slot.
    always_comb begin
        q_mem_d  = q_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            q_mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        q_cnt_d   = q_cnt_q + CW'(push) - CW'(pop);
        out_cnt_d = out_cnt_q + CW'(acc) - CW'(pop);
        rdy_d     = (out_cnt_d < CW'(DEPTH));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) q_mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            q_cnt_q   <= '0;
            out_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            q_mem_q   <= q_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            q_cnt_q   <= q_cnt_d;
            out_cnt_q <= out_cnt_d;
            rdy_q     <= rdy_d;
        end
    end
endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// tb/tb_dmem_bank_ctrl.sv - self-checking bench for dmem_bank_ctrl (DATA_W=32, LATENCY=3)
module tb_dmem_bank_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int BAW = AW + 2;
    localparam int LAT = 3;
    localparam int DEP = LAT + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]     req_size;
    logic [BAW-1:0] req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]  rsp_rdata;

    always #5 clk = ~clk;

    dmem_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;
    int o_m   = 0;
    bit seen  = 0;
    bit stall = 0;
    logic [DW-1:0] hold_d;
    logic          hold_e;
    logic [7:0]    mem_m [1 << BAW] = '{default: 8'h00};
    logic          me;
    logic [DW-1:0] md;

    typedef struct { int t; logic e; logic [DW-1:0] d; } exp_t;
    exp_t expq[$];

    typedef struct {
        logic we; logic [1:0] sz; logic uns; logic [BAW-1:0] a;
        logic [DW-1:0] wd; logic [DW-1:0] xd; logic xe;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Byte-array reference: little-endian assembly and arithmetic sign extension.
    function automatic void model_apply(input logic we, input logic [1:0] sz, input logic uns,
                                        input logic [BAW-1:0] a, input logic [DW-1:0] wd,
                                        output logic e, output logic [DW-1:0] d);
        int nb;
        longint v;
        nb = 1 << sz;
        e  = (nb > 4) || ((int'(a) % nb) != 0);
        d  = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(mem_m[int'(a) + i]) << (8 * i));
                if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
                d = v[31:0];
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            expq.delete();
            o_m   = 0;
            seen  = 0;
            stall = 0;
        end else begin
            chk("req_ready", req_ready, seen && (o_m < DEP));
            chk("rsp_valid", rsp_valid, (expq.size() > 0) && (cyc >= expq[0].t));
            if (stall && rsp_valid) begin
                chk("hold_rdata", rsp_rdata, hold_d);
                chk("hold_err", rsp_err, hold_e);
            end
            stall  = rsp_valid && !rsp_ready;
            hold_d = rsp_rdata;
            hold_e = rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    chk("rsp_rdata", rsp_rdata, expq[0].d);
                    chk("rsp_err", rsp_err, expq[0].e);
                    void'(expq.pop_front());
                    o_m--;
                end
            end
            if (req_valid && req_ready) begin
                model_apply(req_we, req_size, req_unsigned, req_addr, req_wdata, me, md);
                expq.push_back('{cyc + LAT, me, md});
                o_m++;
                acc_cnt++;
            end
            seen = 1;
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [BAW-1:0] a, input logic [DW-1:0] wd);
        int n;
        bit got;
        n = 0;
        got = 0;
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        while (!got && n < 200) begin
            @(negedge clk);
            if (req_ready) got = 1;
            n++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL req_timeout actual=no-accept required=accept addr=%h", a);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output logic e);
        int n;
        bit got;
        n = 0; got = 0; d = '0; e = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                d = rsp_rdata; e = rsp_err; got = 1;
            end
            n++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL rsp_timeout actual=no-response required=response");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic          e;
        logic [13:0]   rv;
        int            vcount;
        int            nb;
        int            off;

        rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        vt.push_back('{1, 2'd0, 0, 12'h100, 32'h11, 32'h0, 0});
        vt.push_back('{1, 2'd0, 0, 12'h101, 32'h22, 32'h0, 0});
        vt.push_back('{1, 2'd0, 0, 12'h102, 32'h33, 32'h0, 0});
        vt.push_back('{1, 2'd0, 0, 12'h103, 32'h44, 32'h0, 0});
        vt.push_back('{0, 2'd2, 0, 12'h100, 32'h0, 32'h44332211, 0});
        vt.push_back('{1, 2'd2, 0, 12'h040, 32'h00008080, 32'h0, 0});
        vt.push_back('{0, 2'd0, 0, 12'h040, 32'h0, 32'hFFFFFF80, 0});
        vt.push_back('{0, 2'd0, 1, 12'h040, 32'h0, 32'h00000080, 0});
        vt.push_back('{0, 2'd1, 0, 12'h040, 32'h0, 32'hFFFF8080, 0});
        vt.push_back('{0, 2'd1, 1, 12'h042, 32'h0, 32'h00000000, 0});
        vt.push_back('{0, 2'd2, 0, 12'h102, 32'h0, 32'h0, 1});
        vt.push_back('{1, 2'd1, 0, 12'h101, 32'hBEEF, 32'h0, 1});
        vt.push_back('{0, 2'd2, 0, 12'h100, 32'h0, 32'h44332211, 0});
        vt.push_back('{0, 2'd3, 0, 12'h100, 32'h0, 32'h0, 1});
        vt.push_back('{0, 2'd1, 1, 12'h102, 32'h0, 32'h00004433, 0});
        vt.push_back('{0, 2'd0, 0, 12'h103, 32'h0, 32'h00000044, 0});
        vt.push_back('{1, 2'd1, 0, 12'h102, 32'hBEEF, 32'h0, 0});
        vt.push_back('{0, 2'd2, 0, 12'h100, 32'h0, 32'hBEEF2211, 0});
        vt.push_back('{0, 2'd1, 0, 12'h102, 32'h0, 32'hFFFFBEEF, 0});
        vt.push_back('{0, 2'd0, 1, 12'h103, 32'h0, 32'h000000BE, 0});
        vt.push_back('{0, 2'd2, 0, 12'h200, 32'h0, 32'h00000000, 0});
        vt.push_back('{1, 2'd0, 0, 12'h041, 32'hAAAAAA7F, 32'h0, 0});
        vt.push_back('{0, 2'd1, 0, 12'h040, 32'h0, 32'h00007F80, 0});
        vt.push_back('{0, 2'd2, 0, 12'h040, 32'h0, 32'h00007F80, 0});

        @(posedge clk); #1;
        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i].we, vt[i].sz, vt[i].uns, vt[i].a, vt[i].wd);
            wait_rsp(d, e);
            chk($sformatf("vec%0d_rdata", i), d, vt[i].xd);
            chk($sformatf("vec%0d_err", i), e, vt[i].xe);
        end

        // Backpressure: only DEP loads get in while responses are held.
        acc_cnt = 0;
        rsp_ready = 0; req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0; req_addr = 12'h100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
            req_addr = req_addr + 12'd4;
        end
        req_valid = 0;
        @(negedge clk);
        chk("stall_accepts", acc_cnt, DEP);
        chk("stall_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_pop", req_ready, 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;

        // Back-to-back loads: 8 consecutive responses starting LAT cycles after the first accept.
        req_valid = 1; req_we = 0; req_size = 2; req_addr = 12'h100;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            rv[j] = rsp_valid;
            if (j < 8) chk($sformatf("b2b_ready%0d", j), req_ready, 1);
            @(posedge clk); #1;
            req_addr  = req_addr + 12'd4;
            req_valid = (j < 7);
        end
        chk("b2b_valid_pattern", rv, 14'h07F8);
        repeat (5) @(posedge clk); #1;

        // Randomized traffic in a separate region, checked by the reference model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            req_valid    = ($urandom_range(0, 3) != 0);
            req_we       = $urandom_range(0, 1);
            req_size     = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_unsigned = $urandom_range(0, 1);
            nb           = 1 << req_size;
            off          = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) off = off & ~(nb - 1) & 3;
            req_addr     = 12'h200 + 12'($urandom_range(0, 31) * 4 + off);
            req_wdata    = $urandom;
            rsp_ready    = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 0; rsp_ready = 1;
        repeat (12) @(posedge clk); #1;

        // Reset with one response queued and two still in the pipeline.
        rsp_ready = 0;
        issue(0, 2'd2, 0, 12'h100, 32'h0);
        issue(0, 2'd2, 0, 12'h104, 32'h0);
        issue(0, 2'd2, 0, 12'h108, 32'h0);
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        rst_n = 0;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1; rsp_ready = 1;
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        chk("no_stale_rsp", vcount, 0);
        @(posedge clk); #1;
        issue(0, 2'd2, 0, 12'h100, 32'h0);
        wait_rsp(d, e);
        chk("post_rst_lw100", d, 32'hBEEF2211);
        for (int k = 0; k < 8; k++) begin
            issue(0, 2'd2, 0, 12'h200 + 12'(k * 4), 32'h0);
            wait_rsp(d, e);
        end

        repeat (10) @(negedge clk);
        chk("drain_queue_empty", expq.size(), 0);
        chk("drain_outstanding", o_m, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
